// File: rtl/router_pkg.sv
// Shared NoC definitions: flit field layout, flit helpers and the
// handshake FSM state encodings used by the processor network interface.
package router_pkg;

    localparam int FLIT_W    = 32;
    localparam int COORD_W   = 1;
    localparam int PAYLOAD_W = FLIT_W - 2 * COORD_W;

    // Field offsets: dst_x occupies the top bits, dst_y sits just below it.
    localparam int DST_X_LSB = FLIT_W - COORD_W;
    localparam int DST_Y_LSB = FLIT_W - 2 * COORD_W;

    typedef enum logic [1:0] {
        T_IDLE,
        T_REQ,
        T_REL
    } tx_state_t;

    typedef enum logic {
        R_WAIT,
        R_ACK
    } rx_state_t;

    function automatic logic [FLIT_W-1:0] make_flit(
        input logic [COORD_W-1:0]   dst_x,
        input logic [COORD_W-1:0]   dst_y,
        input logic [PAYLOAD_W-1:0] payload
    );
        return {dst_x, dst_y, payload};
    endfunction

    function automatic logic [COORD_W-1:0] flit_dst_x(input logic [FLIT_W-1:0] flit);
        return flit[DST_X_LSB +: COORD_W];
    endfunction

    function automatic logic [COORD_W-1:0] flit_dst_y(input logic [FLIT_W-1:0] flit);
        return flit[DST_Y_LSB +: COORD_W];
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO for the network interface. The head entry is visible
// combinationally so a consumer can act on it in the cycle it appears;
// an empty FIFO presents zero on its read port.
module ni_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the registered count, so a pop in the same
    // cycle never frees room for a push into a full FIFO.
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push    = i_wr_en & ~o_full;
    assign w_pop     = i_rd_en & ~o_empty;
    assign o_rd_data = o_empty ? '0 : mem[r_rd_ptr];

    // Storage array; contents need no reset because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_proc_if.sv
// Processor-side network interface for one Corner_Router node: packs
// processor requests into flits and ships them over a 4-phase req/ack
// link, and buffers flits arriving from the router for the processor.
module noc_proc_if #(
    parameter int n        = 32,
    parameter int COORD_W  = 1,
    parameter int SRCX     = 0,
    parameter int SRCY     = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [COORD_W-1:0]     tx_dst_x,
    input  logic [COORD_W-1:0]     tx_dst_y,
    input  logic [n-2*COORD_W-1:0] tx_payload,
    output logic                   rt_out_req,
    input  logic                   rt_out_ack,
    output logic [n-1:0]           rt_out_data,
    input  logic                   rt_in_req,
    output logic                   rt_in_ack,
    input  logic [n-1:0]           rt_in_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [n-1:0]           rx_data,
    output logic [7:0]             misroute_cnt
);

    import router_pkg::tx_state_t;
    import router_pkg::rx_state_t;
    import router_pkg::T_IDLE;
    import router_pkg::T_REQ;
    import router_pkg::T_REL;
    import router_pkg::R_WAIT;
    import router_pkg::R_ACK;

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam logic [COORD_W-1:0] SRC_X_C = COORD_W'(SRCX);
    localparam logic [COORD_W-1:0] SRC_Y_C = COORD_W'(SRCY);

    // ------------------------------------------------------------------
    // Synchronizers for the two handshake inputs from the router.
    // Bit 0: rt_out_ack, bit 1: rt_in_req.
    // ------------------------------------------------------------------
    logic [1:0] w_async_in;
    logic [1:0] w_sync;
    logic       w_ack_sync;
    logic       w_req_sync;

    assign w_async_in = {rt_in_req, rt_out_ack};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic r_meta;
            logic r_stable;
            // Two-flop chain; only r_stable is ever consumed.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_meta   <= 1'b0;
                    r_stable <= 1'b0;
                end else begin
                    r_meta   <= w_async_in[gi];
                    r_stable <= r_meta;
                end
            end
            assign w_sync[gi] = r_stable;
        end
    endgenerate

    assign w_ack_sync = w_sync[0];
    assign w_req_sync = w_sync[1];

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [n-1:0]     w_tx_flit;
    logic [n-1:0]     w_tx_head;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [TX_CW-1:0] w_tx_count;
    logic             w_tx_pop;
    logic             r_tx_avail;
    logic [n-1:0]     r_out_data;
    tx_state_t        r_tx_state;
    tx_state_t        w_tx_state_next;

    assign w_tx_flit = {tx_dst_x, tx_dst_y, tx_payload};
    assign tx_ready  = ~w_tx_full;

    ni_fifo #(
        .WIDTH (n),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .srst      (rst),
        .i_wr_en   (tx_valid),
        .i_wr_data (w_tx_flit),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_full    (w_tx_full),
        .o_empty   (w_tx_empty),
        .o_count   (w_tx_count)
    );

    // Registered occupancy flag keeps FIFO status off the launch decision
    // path; it cannot go stale because a pop is always followed by a full
    // handshake before T_IDLE looks at it again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_avail <= 1'b0;
        end else begin
            r_tx_avail <= (w_tx_count != '0);
        end
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
        end else begin
            r_tx_state <= w_tx_state_next;
        end
    end

    // TX next-state logic: launch, wait for ack high, wait for ack low.
    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            T_IDLE:  if (r_tx_avail) w_tx_state_next = T_REQ;
            T_REQ:   if (w_ack_sync) w_tx_state_next = T_REL;
            T_REL:   if (!w_ack_sync) w_tx_state_next = T_IDLE;
            default: w_tx_state_next = T_IDLE;
        endcase
    end

    // TX outputs decoded purely from state, so req has no input-to-output path.
    always_comb begin
        w_tx_pop   = (r_tx_state == T_IDLE) && r_tx_avail;
        rt_out_req = (r_tx_state == T_REQ);
    end

    // Output flit register: held from launch until the next launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (w_tx_pop) begin
            r_out_data <= w_tx_head;
        end
    end

    assign rt_out_data = r_out_data;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [RX_CW-1:0] w_rx_count;
    logic             w_rx_misroute;
    logic [7:0]       r_misroute_cnt;
    rx_state_t        r_rx_state;
    rx_state_t        w_rx_state_next;

    assign w_rx_pop = rx_ready & ~w_rx_empty;
    assign rx_valid = ~w_rx_empty;

    ni_fifo #(
        .WIDTH (n),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .srst      (rst),
        .i_wr_en   (w_rx_push),
        .i_wr_data (rt_in_data),
        .i_rd_en   (w_rx_pop),
        .o_rd_data (rx_data),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty),
        .o_count   (w_rx_count)
    );

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= R_WAIT;
        end else begin
            r_rx_state <= w_rx_state_next;
        end
    end

    // RX next-state logic: accept only when there is room (backpressure).
    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            R_WAIT:  if (w_req_sync && !w_rx_full) w_rx_state_next = R_ACK;
            R_ACK:   if (!w_req_sync) w_rx_state_next = R_WAIT;
            default: w_rx_state_next = R_WAIT;
        endcase
    end

    // RX outputs: push on the accepting transition, ack from state only.
    always_comb begin
        w_rx_push = (r_rx_state == R_WAIT) && w_req_sync && !w_rx_full;
        rt_in_ack = (r_rx_state == R_ACK);
    end

    assign w_rx_misroute = (rt_in_data[n-1 -: COORD_W] != SRC_X_C) ||
                           (rt_in_data[n-1-COORD_W -: COORD_W] != SRC_Y_C);

    // Saturating count of flits that arrived here but were addressed elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misroute_cnt <= 8'd0;
        end else if (w_rx_push && w_rx_misroute && (r_misroute_cnt != 8'hFF)) begin
            r_misroute_cnt <= r_misroute_cnt + 8'd1;
        end
    end

    assign misroute_cnt = r_misroute_cnt;

    // Status outputs this block has no use for.
    logic w_unused_status;
    assign w_unused_status = w_tx_empty ^ (^w_rx_count);

endmodule

// File: tb/tb_noc_proc_if.sv
// Directed bench for noc_proc_if: TX launch/handshake, TX backpressure,
// RX backpressure, RX simultaneous push/pop, misroute counting and
// reset during a handshake.
module tb_noc_proc_if;

    import router_pkg::*;

    logic        clk;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [0:0]  tx_dst_x;
    logic [0:0]  tx_dst_y;
    logic [29:0] tx_payload;
    logic        rt_out_req;
    logic        rt_out_ack;
    logic [31:0] rt_out_data;
    logic        rt_in_req;
    logic        rt_in_ack;
    logic [31:0] rt_in_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic [7:0]  misroute_cnt;

    int tests_run;
    int tests_failed;

    noc_proc_if #(
        .n        (32),
        .COORD_W  (1),
        .SRCX     (0),
        .SRCY     (0),
        .TX_DEPTH (4),
        .RX_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_dst_x     (tx_dst_x),
        .tx_dst_y     (tx_dst_y),
        .tx_payload   (tx_payload),
        .rt_out_req   (rt_out_req),
        .rt_out_ack   (rt_out_ack),
        .rt_out_data  (rt_out_data),
        .rt_in_req    (rt_in_req),
        .rt_in_ack    (rt_in_ack),
        .rt_in_data   (rt_in_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .misroute_cnt (misroute_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Router side of the TX link: wait for req, capture, 4-phase ack.
    task automatic tx_accept(output logic [31:0] d, output bit ok);
        bit got_req;
        bit got_rel;
        got_req = 1'b0;
        got_rel = 1'b0;
        d = '0;
        for (int c = 0; c <= 30; c++) begin
            if (rt_out_req === 1'b1) begin
                got_req = 1'b1;
                break;
            end
            tick();
        end
        if (got_req) begin
            d = rt_out_data;
            rt_out_ack = 1'b1;
            for (int c = 0; c <= 30; c++) begin
                if (rt_out_req === 1'b0) begin
                    got_rel = 1'b1;
                    break;
                end
                tick();
            end
        end
        rt_out_ack = 1'b0;
        ok = got_req & got_rel;
    endtask

    // Wait (bounded) for rt_in_ack to reach a level.
    task automatic wait_in_ack(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            if (rt_in_ack === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Router side of the RX link: full 4-phase transfer of one flit.
    task automatic rx_send(input logic [31:0] d, output bit ok);
        bit ok_hi;
        bit ok_lo;
        rt_in_data = d;
        rt_in_req  = 1'b1;
        wait_in_ack(1'b1, ok_hi);
        rt_in_req = 1'b0;
        wait_in_ack(1'b0, ok_lo);
        ok = ok_hi & ok_lo;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (rt_out_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req: got %0b expected 0", rt_out_req);
        end
        tests_run++;
        if (rt_out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %08h expected 00000000", rt_out_data);
        end
        tests_run++;
        if (rt_in_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ack: got %0b expected 0", rt_in_ack);
        end
        tests_run++;
        if (rx_valid !== 1'b0 || rx_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rx: got valid=%0b data=%08h expected 0/00000000", rx_valid, rx_data);
        end
        tests_run++;
        if (misroute_cnt !== 8'd0 || tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cnt_ready: got cnt=%0d ready=%0b expected 0/1", misroute_cnt, tx_ready);
        end
        rst = 1'b0;
        tick();
        $display("[TB] reset: outputs checked at reset");
    endtask

    task automatic test_single_tx();
        tx_valid   = 1'b1;
        tx_dst_x   = 1'b1;
        tx_dst_y   = 1'b0;
        tx_payload = 30'h1234567;
        tick();                     // push edge k
        tx_valid = 1'b0;
        tick();                     // k+1: FIFO seen non-empty
        tests_run++;
        if (rt_out_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_req_early: got %0b expected 0 after k+1", rt_out_req);
        end
        tick();                     // k+2: launched
        tests_run++;
        if (rt_out_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_req_rise: got %0b expected 1 after k+2", rt_out_req);
        end
        tests_run++;
        if (rt_out_data !== 32'h81234567) begin
            tests_failed++;
            $display("FAIL tx_data: got %08h expected 81234567", rt_out_data);
        end
        tick();
        rt_out_ack = 1'b1;          // ack rises before edge j
        tick();                     // j
        tick();                     // j+1
        tests_run++;
        if (rt_out_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_req_hold: got %0b expected 1 after j+1", rt_out_req);
        end
        tick();                     // j+2
        tests_run++;
        if (rt_out_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_req_fall: got %0b expected 0 after j+2", rt_out_req);
        end
        tests_run++;
        if (rt_out_data !== 32'h81234567) begin
            tests_failed++;
            $display("FAIL tx_data_held: got %08h expected 81234567", rt_out_data);
        end
        rt_out_ack = 1'b0;
        repeat (4) tick();
        $display("[TB] single_tx: flit %08h handshake complete", rt_out_data);
    endtask

    task automatic test_tx_backpressure();
        logic [0:0]  dx  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [0:0]  dy  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp [5] = '{32'h00000101, 32'h40000102, 32'h80000103,
                                 32'hC0000104, 32'h00000105};
        logic [31:0] d;
        bit          ok;
        bit          extra;
        rt_out_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (tx_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_ready_%0d: got %0b expected 1", i, tx_ready);
            end
            tx_valid   = 1'b1;
            tx_dst_x   = dx[i];
            tx_dst_y   = dy[i];
            tx_payload = 30'h101 + 30'(i);
            tick();
        end
        tx_valid = 1'b0;
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full: got tx_ready=%0b expected 0", tx_ready);
        end
        // Push against a full FIFO must be ignored.
        tx_valid   = 1'b1;
        tx_dst_x   = 1'b1;
        tx_dst_y   = 1'b1;
        tx_payload = 30'h1FF;
        tick();
        tx_valid = 1'b0;
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full_hold: got tx_ready=%0b expected 0", tx_ready);
        end
        for (int i = 0; i < 5; i++) begin
            tx_accept(d, ok);
            tests_run++;
            if (!ok || d !== exp[i]) begin
                tests_failed++;
                $display("FAIL bp_flit_%0d: got %08h (handshake ok=%0b) expected %08h", i, d, ok, exp[i]);
            end
            $display("[TB] bp: flit %0d = %08h", i, d);
        end
        extra = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (rt_out_req === 1'b1) extra = 1'b1;
            tick();
        end
        tests_run++;
        if (extra) begin
            tests_failed++;
            $display("FAIL bp_refused_push: got extra req expected none");
        end
        tests_run++;
        if (tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_drained_ready: got %0b expected 1", tx_ready);
        end
    endtask

    task automatic test_rx_full();
        bit ok;
        rx_ready = 1'b0;
        // First flit with explicit latency check.
        rt_in_data = 32'h00000200;
        rt_in_req  = 1'b1;
        tick();
        tick();
        tests_run++;
        if (rt_in_ack !== 1'b0 || rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_early: got ack=%0b valid=%0b expected 0/0 after j+1", rt_in_ack, rx_valid);
        end
        tick();
        tests_run++;
        if (rt_in_ack !== 1'b1 || rx_valid !== 1'b1 || rx_data !== 32'h00000200) begin
            tests_failed++;
            $display("FAIL rx_latency: got ack=%0b valid=%0b data=%08h expected 1/1/00000200", rt_in_ack, rx_valid, rx_data);
        end
        rt_in_req = 1'b0;
        wait_in_ack(1'b0, ok);
        for (int i = 1; i < 4; i++) begin
            rx_send(32'h00000200 + 32'(i), ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL rx_fill_%0d: got no handshake expected ack", i);
            end
        end
        // Fifth flit: FIFO full, ack must be withheld.
        rt_in_data = 32'h00000204;
        rt_in_req  = 1'b1;
        repeat (8) tick();
        tests_run++;
        if (rt_in_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_backpressure: got ack=%0b expected 0", rt_in_ack);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tests_run++;
        if (rx_data !== 32'h00000201) begin
            tests_failed++;
            $display("FAIL rx_pop_head: got %08h expected 00000201", rx_data);
        end
        wait_in_ack(1'b1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rx_release: got ack=%0b expected 1 after pop", rt_in_ack);
        end
        rt_in_req = 1'b0;
        wait_in_ack(1'b0, ok);
        rx_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tests_run++;
            if (rx_valid !== 1'b1 || rx_data !== 32'h00000200 + 32'(i)) begin
                tests_failed++;
                $display("FAIL rx_order_%0d: got valid=%0b data=%08h expected 1/%08h", i, rx_valid, rx_data, 32'h00000200 + 32'(i));
            end
            $display("[TB] rx_full: popped %08h", rx_data);
            tick();
        end
        rx_ready = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0 || rx_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL rx_empty: got valid=%0b data=%08h expected 0/00000000", rx_valid, rx_data);
        end
    endtask

    task automatic test_rx_push_pop();
        bit ok;
        rx_ready = 1'b0;
        rx_send(32'h0000A001, ok);
        rx_send(32'h0000A002, ok);
        rt_in_data = 32'h0000A003;
        rt_in_req  = 1'b1;
        tick();
        tick();
        rx_ready = 1'b1;            // pop coincides with the push edge
        tick();
        rx_ready = 1'b0;
        tests_run++;
        if (rt_in_ack !== 1'b1 || rx_data !== 32'h0000A002) begin
            tests_failed++;
            $display("FAIL pushpop_head: got ack=%0b data=%08h expected 1/0000a002", rt_in_ack, rx_data);
        end
        rt_in_req = 1'b0;
        wait_in_ack(1'b0, ok);
        rx_ready = 1'b1;
        tests_run++;
        if (rx_data !== 32'h0000A002) begin
            tests_failed++;
            $display("FAIL pushpop_first: got %08h expected 0000a002", rx_data);
        end
        tick();
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h0000A003) begin
            tests_failed++;
            $display("FAIL pushpop_second: got valid=%0b data=%08h expected 1/0000a003", rx_valid, rx_data);
        end
        tick();
        rx_ready = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL pushpop_count: got valid=%0b expected 0 after two pops", rx_valid);
        end
        $display("[TB] rx_push_pop: two entries retained across push+pop");
    endtask

    task automatic test_misroute();
        bit ok;
        rx_ready = 1'b0;
        rx_send(32'hC0000055, ok);
        tests_run++;
        if (!ok || rx_data !== 32'hC0000055) begin
            tests_failed++;
            $display("FAIL misroute_deliver: got %08h (ok=%0b) expected c0000055", rx_data, ok);
        end
        tests_run++;
        if (misroute_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL misroute_one: got %0d expected 1", misroute_cnt);
        end
        rx_ready = 1'b1;
        tick();
        for (int i = 1; i < 255; i++) begin
            rx_send(32'hC0000000 + 32'(i), ok);
        end
        tick();
        tests_run++;
        if (misroute_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL misroute_255: got %0d expected 255", misroute_cnt);
        end
        for (int i = 255; i < 300; i++) begin
            rx_send(32'hC0000000 + 32'(i), ok);
        end
        tick();
        rx_ready = 1'b0;
        tests_run++;
        if (misroute_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL misroute_sat: got %0d expected 255", misroute_cnt);
        end
        $display("[TB] misroute: count=%0d after 300 flits", misroute_cnt);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit extra;
        rx_ready = 1'b0;
        rx_send(32'h00000077, ok);
        rt_out_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_valid   = 1'b1;
            tx_dst_x   = 1'b0;
            tx_dst_y   = 1'b1;
            tx_payload = 30'h300 + 30'(i);
            tick();
        end
        tx_valid = 1'b0;
        tick();
        tests_run++;
        if (rt_out_req !== 1'b1 || rx_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_setup: got req=%0b rx_valid=%0b expected 1/1", rt_out_req, rx_valid);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (rt_out_req !== 1'b0 || rt_in_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_req: got req=%0b ack=%0b expected 0/0", rt_out_req, rt_in_ack);
        end
        tests_run++;
        if (tx_ready !== 1'b1 || rx_valid !== 1'b0 || rt_out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL rstmid_clear: got ready=%0b rx_valid=%0b data=%08h expected 1/0/00000000", tx_ready, rx_valid, rt_out_data);
        end
        tests_run++;
        if (misroute_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL rstmid_cnt: got %0d expected 0", misroute_cnt);
        end
        rst = 1'b0;
        tick();
        test_single_tx();
        extra = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (rt_out_req === 1'b1) extra = 1'b1;
            tick();
        end
        tests_run++;
        if (extra) begin
            tests_failed++;
            $display("FAIL rstmid_discard: got stale flit req expected none");
        end
        $display("[TB] reset_mid: buffered flits discarded");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_dst_x   = 1'b0;
        tx_dst_y   = 1'b0;
        tx_payload = '0;
        rt_out_ack = 1'b0;
        rt_in_req  = 1'b0;
        rt_in_data = '0;
        rx_ready   = 1'b0;
        test_reset();
        test_single_tx();
        test_tx_backpressure();
        test_rx_full();
        test_rx_push_pop();
        test_misroute();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
